// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, helpers and types for the register-file
//                busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default register address width and index of the hardwired zero register
    localparam int c_ADDR_WIDTH = 5;
    localparam int c_ZERO_REG   = 0;

    // Number of architectural registers addressed by an aw-bit index
    function automatic int num_regs(input int aw);
        return 1 << aw;
    endfunction

    localparam int c_NUM_REGS = 1 << c_ADDR_WIDTH;

    // Busy vector for the default register file size
    typedef logic [c_NUM_REGS-1:0] busy_vec_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/decoder_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_onehot
//  Description : Enable-gated binary-to-one-hot decoder. Output 0 can be
//                permanently suppressed for a hardwired zero register.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_onehot #(
    parameter int ADDR_WIDTH    = 5,
    parameter int SUPPRESS_ZERO = 1
) (
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic                       i_en,
    output logic [(1<<ADDR_WIDTH)-1:0] o_onehot
);

    localparam int c_NUM_OUT = 1 << ADDR_WIDTH;

    // One output line per register; line 0 is tied low when suppressed
    for (genvar i = 0; i < c_NUM_OUT; i++) begin : g_bit
        if ((i == 0) && (SUPPRESS_ZERO != 0)) begin : g_zero_off
            assign o_onehot[i] = 1'b0;
        end else begin : g_dec
            assign o_onehot[i] = i_en & (i_addr == ADDR_WIDTH'(i));
        end
    end

endmodule : decoder_onehot
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register in-flight write tracker. Issue marks the
//                destination busy, writeback clears it; source lookups and
//                issue acceptance are combinational so decode can stall on
//                RAW and WAW hazards in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH         = c_ADDR_WIDTH,
    parameter int NUM_RD_PORTS       = 2,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int WB_BYPASS          = 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic                               issue_valid,
    input  logic [ADDR_WIDTH-1:0]              issue_rd,
    output logic                               issue_ready,
    input  logic                               wb_valid,
    input  logic [ADDR_WIDTH-1:0]              wb_rd,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] src_addr,
    output logic [NUM_RD_PORTS-1:0]            src_busy,
    output logic [(1<<ADDR_WIDTH)-1:0]         busy_vec,
    output logic [ADDR_WIDTH:0]                busy_count,
    output logic                               wb_err
);

    localparam int              NUM_REGS    = num_regs(ADDR_WIDTH);
    localparam logic            c_ZERO_EN   = (ZERO_REG_HARDWIRED != 0);
    localparam logic            c_BYPASS_EN = (WB_BYPASS != 0);
    localparam [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(c_ZERO_REG);

    logic [NUM_REGS-1:0] r_busy_vec;
    logic [ADDR_WIDTH:0] r_busy_count;
    logic                r_wb_err;

    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [ADDR_WIDTH:0] w_count_next;
    logic                w_issue_fire;
    logic                w_issue_busy_eff;
    logic                w_wb_err_next;
    logic                w_count_inc;
    logic                w_count_dec;

    // A destination held by an in-flight write blocks issue unless that
    // write is retiring this very cycle (new producer replaces the old one).
    assign w_issue_busy_eff = r_busy_vec[issue_rd] & ~(wb_valid & (wb_rd == issue_rd));
    assign issue_ready      = ~w_issue_busy_eff & ~flush;
    assign w_issue_fire     = issue_valid & issue_ready;

    decoder_onehot #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .SUPPRESS_ZERO (ZERO_REG_HARDWIRED)
    ) u_set_dec (
        .i_addr   (issue_rd),
        .i_en     (w_issue_fire),
        .o_onehot (w_set_mask)
    );

    decoder_onehot #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .SUPPRESS_ZERO (ZERO_REG_HARDWIRED)
    ) u_clr_dec (
        .i_addr   (wb_rd),
        .i_en     (wb_valid),
        .o_onehot (w_clr_mask)
    );

    // Next busy vector and incremental population count; set wins over clear
    always_comb begin
        w_busy_next  = (r_busy_vec & ~w_clr_mask) | w_set_mask;
        // Issue can only hit an already-busy register when that register is
        // being cleared in the same cycle, in which case the count is unchanged.
        w_count_inc  = |(w_set_mask & ~r_busy_vec);
        w_count_dec  = |(w_clr_mask & r_busy_vec & ~w_set_mask);
        w_count_next = r_busy_count
                       + {{ADDR_WIDTH{1'b0}}, w_count_inc}
                       - {{ADDR_WIDTH{1'b0}}, w_count_dec};
    end

    // A writeback to an idle register is a protocol error; the zero
    // register absorbs writes silently when hardwired.
    assign w_wb_err_next = wb_valid & ~r_busy_vec[wb_rd] & ~flush
                           & ~(c_ZERO_EN & (wb_rd == c_ZERO_ADDR));

    // Busy state, count and error pulse; reset beats flush beats normal update
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_busy_vec   <= '0;
            r_busy_count <= '0;
            r_wb_err     <= 1'b0;
        end else if (flush) begin
            r_busy_vec   <= '0;
            r_busy_count <= '0;
            r_wb_err     <= 1'b0;
        end else begin
            r_busy_vec   <= w_busy_next;
            r_busy_count <= w_count_next;
            r_wb_err     <= w_wb_err_next;
        end
    end

    // Per-port source lookup with optional same-cycle writeback bypass
    for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_src
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr      = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign src_busy[i] = r_busy_vec[w_addr]
                             & ~(c_BYPASS_EN & wb_valid & (wb_rd == w_addr))
                             & ~(c_ZERO_EN & (w_addr == c_ZERO_ADDR));
    end

    assign busy_vec   = r_busy_vec;
    assign busy_count = r_busy_count;
    assign wb_err     = r_wb_err;

endmodule : regfile_scoreboard
`default_nettype wire
